hazard_stall_ctrl: RTL

//  Drives the enable_bar (stall) and flush/reset inputs of the M_S_FF pipeline registers
//  (PC, IF/ID, ID/EX), acting as the controlling end of their stall interface.
//  - Detects load-use hazards and inserts one bubble.
//  - Tracks a multi-cycle mult/div unit and stalls dependent HI/LO reads.
//  - Flushes the wrong-path instructions on a taken branch.
//  - Keeps a saturating stall-cycle counter for debug.

---
 rtl/hazard_stall_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubble, mult/div HI/LO interlock,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_reads_hilo,
  input  logic              id_is_md,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_md_start,
  input  logic              branch_taken,
  output logic              pc_enable_bar,
  output logic              if_id_enable_bar,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic md_haz;
  logic stall;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    md_busy  = !rst && (state_q == S_MD_BUSY);
    md_haz   = md_busy && (id_reads_hilo || id_is_md);
    stall    = !rst && (load_use || md_haz) && !branch_taken;
  end

  always_comb begin
    pc_enable_bar    = 1'b0;
    if_id_enable_bar = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    if (rst) begin
      pc_enable_bar    = 1'b0;
    end else if (branch_taken) begin
      if_id_flush      = 1'b1;
      id_ex_flush      = 1'b1;
    end else if (stall) begin
      pc_enable_bar    = 1'b1;
      if_id_enable_bar = 1'b1;
      id_ex_flush      = 1'b1;
    end
  end

  // A start while already busy reloads the countdown rather than being ignored.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_md_start) begin
          state_d  = S_MD_BUSY;
          md_cnt_d = CNT_W'(MD_CYCLES - 1);
        end
      end
      S_MD_BUSY: begin
        if (ex_md_start) begin
          md_cnt_d = CNT_W'(MD_CYCLES - 1);
        end else if (md_cnt_q == CNT_W'(1)) begin
          state_d  = S_IDLE;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
